// File: rtl/rect_cmd_queue.sv
// -----------------------------------------------------------------------------
// rect_cmd_queue
//
// Purpose:
//   Buffers rectangle draw commands in a DEPTH-entry FIFO and sequences them,
//   one at a time, into a downstream rectangle renderer. Each popped command
//   is latched into the rect_* attribute registers. The renderer is then
//   enabled, and the queue waits for its done flag. Commands with zero width
//   or zero height are dropped without enabling the renderer.
//
// Optional feature (compile-time macro):
//   RECT_CLIP_EN - clip popped commands to a 320x240 screen. A command whose
//                  origin is off-screen is dropped like a zero-size command.
//
// Ports:
//   clk, reset         clock (all state on rising edge); async active-high reset
//   cmd_valid/ready    command handshake from the producer
//   cmd_*              command origin, size, background, border flag/colour
//   rect_*             registered attributes to the renderer
//   rect_enable        renderer enable (high only in DRAW)
//   rect_done          renderer done (combinational, valid while enabled)
//   cmd_done           one-cycle pulse per command completed or dropped
//   busy               FSM not idle or FIFO non-empty
//   level              FIFO occupancy
//   fsm_state_o        current FSM state (debug)
//
// Handshake:
//   A command is pushed on a rising clk edge where cmd_valid && cmd_ready.
//   cmd_ready depends only on registered occupancy and never on cmd_valid.
//   The producer must hold cmd_valid and cmd_* stable until it is accepted.
// -----------------------------------------------------------------------------
module rect_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [8:0]             cmd_x,
    input  logic [7:0]             cmd_y,
    input  logic [8:0]             cmd_w,
    input  logic [7:0]             cmd_h,
    input  logic [2:0]             cmd_back,
    input  logic                   cmd_border,
    input  logic [2:0]             cmd_border_color,
    output logic [8:0]             rect_origin_x,
    output logic [7:0]             rect_origin_y,
    output logic [8:0]             rect_width,
    output logic [7:0]             rect_height,
    output logic [2:0]             rect_back_color,
    output logic                   rect_border,
    output logic [2:0]             rect_border_color,
    output logic                   rect_enable,
    input  logic                   rect_done,
    output logic                   cmd_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             fsm_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 41;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DRAW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         state_q, state_d;

    // FIFO storage and bookkeeping
    logic [CW-1:0]  fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;

    // Sequencing flags
    logic           armed_q, armed_d;
    logic           drop_q, drop_d;

    // Attribute registers
    logic [8:0]     ox_q, ox_d;
    logic [7:0]     oy_q, oy_d;
    logic [8:0]     w_q, w_d;
    logic [7:0]     h_q, h_d;
    logic [2:0]     back_q, back_d;
    logic           brd_q, brd_d;
    logic [2:0]     bc_q, bc_d;

    logic           push;
    logic           pop;
    logic           load_attr;
    logic           fifo_nonempty;
    logic [CW-1:0]  cmd_word;
    logic [CW-1:0]  head_word;

    logic [8:0]     head_x;
    logic [7:0]     head_y;
    logic [8:0]     head_w;
    logic [7:0]     head_h;
    logic [2:0]     head_back;
    logic           head_brd;
    logic [2:0]     head_bc;
    logic [8:0]     eff_w;
    logic [7:0]     eff_h;
    logic           head_drop;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    assign fifo_nonempty = (level_q != '0);
    assign cmd_ready     = (level_q < LW'(DEPTH));
    assign push          = cmd_valid & cmd_ready;

    assign cmd_word = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border,
                       cmd_border_color};
    assign head_word = fifo_q[rd_ptr_q];
    assign {head_x, head_y, head_w, head_h, head_back, head_brd, head_bc} =
        head_word;

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is not reset; entries are only read once pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // -------------------------------------------------------------------------
    // Head-of-queue size evaluation
    // -------------------------------------------------------------------------
`ifdef RECT_CLIP_EN
    logic [9:0] room_x;
    logic [8:0] room_y;

    always_comb begin
        room_x = 10'd320 - {1'b0, head_x};
        room_y = 9'd240 - {1'b0, head_y};
        eff_w  = head_w;
        eff_h  = head_h;
        if ((head_x >= 9'd320) || (head_y >= 8'd240)) begin
            // Off-screen origin: force a zero size so it takes the drop path
            eff_w = '0;
            eff_h = '0;
        end else begin
            if ({1'b0, head_w} > room_x) begin
                eff_w = room_x[8:0];
            end
            if ({1'b0, head_h} > room_y) begin
                eff_h = room_y[7:0];
            end
        end
    end
`else
    assign eff_w = head_w;
    assign eff_h = head_h;
`endif

    assign head_drop = (eff_w == '0) | (eff_h == '0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A dropped head is consumed here without leaving IDLE
                if (fifo_nonempty && !head_drop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (armed_q && rect_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs and per-state controls
    // -------------------------------------------------------------------------
    always_comb begin
        pop         = 1'b0;
        load_attr   = 1'b0;
        drop_d      = 1'b0;
        armed_d     = 1'b0;
        rect_enable = 1'b0;
        cmd_done    = drop_q;
        busy        = (state_q != S_IDLE) | fifo_nonempty;
        case (state_q)
            S_IDLE: begin
                pop       = fifo_nonempty;
                load_attr = fifo_nonempty & ~head_drop;
                drop_d    = fifo_nonempty & head_drop;
            end
            S_LOAD: begin
                rect_enable = 1'b0;
            end
            S_DRAW: begin
                rect_enable = 1'b1;
                // The renderer may report done left over from its previous
                // draw; only trust done after it has been seen low once.
                armed_d     = armed_q | ~rect_done;
            end
            S_RELEASE: begin
                cmd_done = 1'b1;
            end
            default: begin
                rect_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            drop_q  <= drop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Attribute registers: loaded only on a pop that will be drawn, so they
    // stay constant from LOAD through RELEASE.
    // -------------------------------------------------------------------------
    always_comb begin
        ox_d   = ox_q;
        oy_d   = oy_q;
        w_d    = w_q;
        h_d    = h_q;
        back_d = back_q;
        brd_d  = brd_q;
        bc_d   = bc_q;
        if (load_attr) begin
            ox_d   = head_x;
            oy_d   = head_y;
            w_d    = eff_w;
            h_d    = eff_h;
            back_d = head_back;
            brd_d  = head_brd;
            bc_d   = head_bc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox_q   <= '0;
            oy_q   <= '0;
            w_q    <= '0;
            h_q    <= '0;
            back_q <= '0;
            brd_q  <= 1'b0;
            bc_q   <= '0;
        end else begin
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            w_q    <= w_d;
            h_q    <= h_d;
            back_q <= back_d;
            brd_q  <= brd_d;
            bc_q   <= bc_d;
        end
    end

    assign rect_origin_x     = ox_q;
    assign rect_origin_y     = oy_q;
    assign rect_width        = w_q;
    assign rect_height       = h_q;
    assign rect_back_color   = back_q;
    assign rect_border       = brd_q;
    assign rect_border_color = bc_q;
    assign level             = level_q;
    assign fsm_state_o       = state_q;

endmodule

// File: tb/tb_rect_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_rect_cmd_queue
//
// Bench for rect_cmd_queue (DEPTH=4). A per-cycle vector table covers reset
// and a single command's full life cycle. Hand-written sequences cover FIFO
// back-pressure, the done-glitch masking, zero-size drops, reset during a
// draw, and clipping when RECT_CLIP_EN is defined.
// -----------------------------------------------------------------------------
module tb_rect_cmd_queue;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [8:0]    cmd_x;
  logic [7:0]    cmd_y;
  logic [8:0]    cmd_w;
  logic [7:0]    cmd_h;
  logic [2:0]    cmd_back;
  logic          cmd_border;
  logic [2:0]    cmd_border_color;
  logic [8:0]    rect_origin_x;
  logic [7:0]    rect_origin_y;
  logic [8:0]    rect_width;
  logic [7:0]    rect_height;
  logic [2:0]    rect_back_color;
  logic          rect_border;
  logic [2:0]    rect_border_color;
  logic          rect_enable;
  logic          rect_done;
  logic          cmd_done;
  logic          busy;
  logic [LW-1:0] level;
  logic [1:0]    fsm_state_o;

  rect_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_x             (cmd_x),
    .cmd_y             (cmd_y),
    .cmd_w             (cmd_w),
    .cmd_h             (cmd_h),
    .cmd_back          (cmd_back),
    .cmd_border        (cmd_border),
    .cmd_border_color  (cmd_border_color),
    .rect_origin_x     (rect_origin_x),
    .rect_origin_y     (rect_origin_y),
    .rect_width        (rect_width),
    .rect_height       (rect_height),
    .rect_back_color   (rect_back_color),
    .rect_border       (rect_border),
    .rect_border_color (rect_border_color),
    .rect_enable       (rect_enable),
    .rect_done         (rect_done),
    .cmd_done          (cmd_done),
    .busy              (busy),
    .level             (level),
    .fsm_state_o       (fsm_state_o)
  );

  // ---------------- renderer model ----------------
  // Auto mode: done rises on the third enabled cycle; manual mode: bench-driven.
  logic rd_auto   = 1'b0;
  logic rd_manual = 1'b0;
  int   rcnt      = 0;
  always @(posedge clk) rcnt <= rect_enable ? rcnt + 1 : 0;
  assign rect_done = rd_auto ? (rect_enable && (rcnt >= 2)) : rd_manual;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [40:0] pk(input logic [8:0] x, input logic [7:0] y,
                                     input logic [8:0] w, input logic [7:0] h,
                                     input logic [2:0] b, input logic brd,
                                     input logic [2:0] bc);
    return {x, y, w, h, b, brd, bc};
  endfunction

  function automatic logic [40:0] cur_attr();
    return {rect_origin_x, rect_origin_y, rect_width, rect_height,
            rect_back_color, rect_border, rect_border_color};
  endfunction

  // Reference: expected drawn attributes for a command; 0 if it is dropped
  function automatic logic exp_ok(input logic [40:0] c, output logic [40:0] e);
    int x, y, wi, hi;
    x  = int'(c[40:32]);
    y  = int'(c[31:24]);
    wi = int'(c[23:15]);
    hi = int'(c[14:7]);
`ifdef RECT_CLIP_EN
    if (x >= 320 || y >= 240) begin
      wi = 0;
      hi = 0;
    end else begin
      if (wi > 320 - x) wi = 320 - x;
      if (hi > 240 - y) hi = 240 - y;
    end
`endif
    e = {c[40:24], wi[8:0], hi[7:0], c[6:0]};
    return (wi != 0) && (hi != 0);
  endfunction

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q[$];
  logic        mon_en   = 1'b0;
  logic        en_prev  = 1'b0;
  logic [40:0] held     = '0;
  int          rise_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rect_enable && !en_prev) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL draw_order: got draw of %0h, expected no draw", cur_attr());
        end else begin
          check("draw_order", 64'(cur_attr()), 64'(exp_q.pop_front()));
        end
        held <= cur_attr();
      end else if (rect_enable) begin
        check("attr_hold", 64'(cur_attr()), 64'(held));
      end
      if (cmd_done) done_cnt++;
    end
    en_prev <= rect_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [40:0] c);
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_border_color} = c;
  endtask

  task automatic push_cmd(input logic [40:0] c, input int budget);
    logic        acc;
    logic [40:0] e;
    acc = 1'b0;
    set_cmd(c);
    cmd_valid = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("push_accept", 64'(acc), 64'(1));
    if (acc && exp_ok(c, e)) exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b0) got = 1'b1;
      @(posedge clk);
      #1;
    end
    check(name, 64'(got), 64'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic          rd;
    logic          e_ready;
    logic          e_en;
    logic          e_done;
    logic          e_busy;
    logic [LW-1:0] e_level;
    logic [40:0]   e_attr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic rd, input logic rdy,
                              input logic en, input logic dn, input logic bz,
                              input logic [LW-1:0] lv, input logic [40:0] at);
    vec_t t;
    t.v = v; t.rd = rd; t.e_ready = rdy; t.e_en = en; t.e_done = dn;
    t.e_busy = bz; t.e_level = lv; t.e_attr = at;
    return t;
  endfunction

  vec_t vt[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [40:0] a_cmd;
    logic        got;
    int          base_rise, base_done;

    reset = 1'b1;
    cmd_valid = 1'b0;
    set_cmd('0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_enable", 64'(rect_enable), 64'(0));
    check("rst_cmd_done", 64'(cmd_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_attr", 64'(cur_attr()), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- single command, cycle by cycle ----
    a_cmd = pk(9'd10, 8'd20, 9'd4, 8'd3, 3'b010, 1'b1, 3'b101);
    //         v    rd   rdy  en   done busy lvl
    vt[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0);     // IDLE, push
    vt[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, '0);     // IDLE, pop
    vt[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, a_cmd);  // LOAD
    vt[3] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, a_cmd);  // DRAW, arms
    vt[4] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, a_cmd);  // DRAW
    vt[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, a_cmd);  // DRAW, done
    vt[6] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, a_cmd);  // RELEASE
    vt[7] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, a_cmd);  // IDLE
    for (int i = 0; i < 8; i++) begin
      set_cmd(a_cmd);
      cmd_valid = vt[i].v;
      rd_manual = vt[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 64'(cmd_ready), 64'(vt[i].e_ready));
      check($sformatf("vec%0d_enable", i), 64'(rect_enable), 64'(vt[i].e_en));
      check($sformatf("vec%0d_cmd_done", i), 64'(cmd_done), 64'(vt[i].e_done));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].e_level));
      check($sformatf("vec%0d_attr", i), 64'(cur_attr()), 64'(vt[i].e_attr));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    rd_manual = 1'b0;
    mon_en    = 1'b1;

    // ---- back-pressure: 5 back-to-back, then a 6th ----
    rd_auto   = 1'b1;
    base_rise = rise_cnt;
    base_done = done_cnt;
    for (int k = 0; k < 5; k++) begin
      push_cmd(pk(9'(k * 20), 8'(k * 10), 9'(5 + k), 8'(4 + k), 3'(k), 1'(k),
                  3'(7 - k)), 4);
    end
    @(negedge clk);
    check("full_level", 64'(level), 64'(4));
    check("full_ready", 64'(cmd_ready), 64'(0));
    check("full_enable", 64'(rect_enable), 64'(1));
    @(posedge clk);
    #1;
    push_cmd(pk(9'd100, 8'd100, 9'd9, 8'd9, 3'd6, 1'b1, 3'd1), 100);
    check("sixth_after_first_done", 64'(done_cnt - base_done), 64'(1));
    wait_idle("bp_idle");
    check("bp_draws", 64'(rise_cnt - base_rise), 64'(6));
    check("bp_dones", 64'(done_cnt - base_done), 64'(6));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // ---- stale done masking ----
    rd_auto   = 1'b0;
    rd_manual = 1'b1;
    base_rise = rise_cnt;
    base_done = done_cnt;
    push_cmd(pk(9'd50, 8'd60, 9'd7, 8'd8, 3'd3, 1'b0, 3'd4), 4);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (rect_enable === 1'b1) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("glitch_start", 64'(got), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("glitch_draw2", 64'(rect_enable), 64'(1));
    @(posedge clk);
    #1;
    rd_manual = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("glitch_low%0d", i), 64'(rect_enable), 64'(1));
      @(posedge clk);
      #1;
    end
    rd_manual = 1'b1;
    @(negedge clk);
    check("glitch_rise_enable", 64'(rect_enable), 64'(1));
    check("glitch_rise_cmd_done", 64'(cmd_done), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_enable", 64'(rect_enable), 64'(0));
    check("release_cmd_done", 64'(cmd_done), 64'(1));
    check("release_state", 64'(fsm_state_o), 64'(3));
    @(posedge clk);
    #1;
    rd_manual = 1'b0;
    wait_idle("glitch_idle");
    check("glitch_draws", 64'(rise_cnt - base_rise), 64'(1));
    check("glitch_dones", 64'(done_cnt - base_done), 64'(1));

    // ---- zero-size drop between two valid commands ----
    rd_auto   = 1'b1;
    base_rise = rise_cnt;
    base_done = done_cnt;
    push_cmd(pk(9'd1, 8'd2, 9'd3, 8'd4, 3'd1, 1'b0, 3'd0), 4);
    push_cmd(pk(9'd5, 8'd6, 9'd0, 8'd5, 3'd2, 1'b1, 3'd7), 4);
    push_cmd(pk(9'd7, 8'd8, 9'd2, 8'd2, 3'd5, 1'b1, 3'd2), 4);
    wait_idle("drop_idle");
    check("drop_draws", 64'(rise_cnt - base_rise), 64'(2));
    check("drop_dones", 64'(done_cnt - base_done), 64'(3));
    check("drop_queue_empty", 64'(exp_q.size()), 64'(0));

    // ---- reset while drawing with two queued ----
    rd_auto   = 1'b0;
    rd_manual = 1'b0;
    base_rise = rise_cnt;
    base_done = done_cnt;
    push_cmd(pk(9'd30, 8'd31, 9'd6, 8'd6, 3'd7, 1'b0, 3'd3), 4);
    push_cmd(pk(9'd40, 8'd41, 9'd6, 8'd6, 3'd6, 1'b1, 3'd3), 4);
    push_cmd(pk(9'd50, 8'd51, 9'd6, 8'd6, 3'd5, 1'b0, 3'd3), 4);
    @(negedge clk);
    check("pre_rst_enable", 64'(rect_enable), 64'(1));
    check("pre_rst_level", 64'(level), 64'(2));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_enable", 64'(rect_enable), 64'(0));
    check("async_rst_level", 64'(level), 64'(0));
    check("async_rst_cmd_done", 64'(cmd_done), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_ready", 64'(cmd_ready), 64'(1));
    check("async_rst_width", 64'(rect_width), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_draws", 64'(rise_cnt - base_rise), 64'(1));
    check("post_rst_dones", 64'(done_cnt - base_done), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));

`ifdef RECT_CLIP_EN
    // ---- clipping ----
    rd_auto   = 1'b1;
    base_rise = rise_cnt;
    base_done = done_cnt;
    push_cmd(pk(9'd300, 8'd230, 9'd50, 8'd20, 3'd1, 1'b0, 3'd2), 4);
    wait_idle("clip_idle");
    check("clip_width", 64'(rect_width), 64'(20));
    check("clip_height", 64'(rect_height), 64'(10));
    push_cmd(pk(9'd320, 8'd10, 9'd5, 8'd5, 3'd1, 1'b0, 3'd2), 4);
    wait_idle("clip_drop_idle");
    check("clip_draws", 64'(rise_cnt - base_rise), 64'(1));
    check("clip_dones", 64'(done_cnt - base_done), 64'(2));
`endif

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
